serial_count_seq: RTL and testbench
===================================

# serial_count_seq

Bit-serial counter sequencer that sits directly upstream of the team's one-bit registered full adder (`adder`) in the counter datapath. On each `start` it streams the current count and a step value LSB-first into the adder, chains the carry, and collects the returned sum bits. It then commits the new count and reports overflow. One adder plus this sequencer forms a WIDTH-bit accumulating counter.

## Interface
- `WIDTH`, default 8, counter and step width in bits (≥2).
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous reset, active-low (0 = reset).
- `start`  in  1  request one add of `step`; honoured only when idle.
- `clr`  in  1  synchronous clear of `count`/`overflow`; honoured only when idle, has priority over `start`.
- `step`  in  WIDTH  increment value, sampled on the accepting edge.
- `busy`  out  1  high from the accepting edge until `done`.
- `done`  out  1  one-cycle pulse when `count` is updated.
- `count`  out  WIDTH  committed counter value.
- `overflow`  out  1  carry-out of the last add, sticky until the next add or clear.
- `add_a`  out  1  count bit to adder.
- `add_b`  out  1  step bit to adder.
- `add_cin`  out  1  carry-in to adder.
- `add_s`  in  1  adder sum, valid one cycle after its operands.
- `add_cout`  in  1  adder carry-out, valid one cycle after its operands.

## Operation
- **Reset.** All outputs are 0: `count`=0, `overflow`=0, `busy`=0, `done`=0, `add_a/add_b/add_cin`=0. The FSM enters IDLE. Reset mid-operation aborts the add; the partial result is discarded.
- **FSM states:** IDLE, SHIFT, DRAIN, DONE.
- **IDLE**
  - `clr`=1 → `count`=0, `overflow`=0; stay IDLE.
  - else `start`=1 → latch `step` and `count` into operand shift registers, bit index k=0; go to SHIFT.
  - `add_*` held at 0.
- **SHIFT** (exactly WIDTH cycles, k = 0..WIDTH-1)
  - Drive `add_a` = count bit k, `add_b` = step bit k.
  - `add_cin` = 0 when k=0, else the `add_cout` returned for bit k-1. This carry is combinational pass-through of the adder's registered output.
  - From k≥1, capture `add_s` as result bit k-1.
  - Go to DRAIN after k=WIDTH-1.
- **DRAIN** (1 cycle)
  - Capture `add_s` as result bit WIDTH-1 and `add_cout` as the final carry.
  - `add_*` = 0.
- **DONE** (1 cycle)
  - `count` ← result, `overflow` ← final carry, `done`=1.
  - Next state is IDLE.
- **Arithmetic.** `count` = (count + step) mod 2^WIDTH; `overflow` = carry out of bit WIDTH-1.
- **Ignored inputs.** `start` and `clr` are ignored while `busy`. Changes to `step` after acceptance have no effect.
- **Visibility.** `count` is visible unchanged during an add; there are no intermediate values.

## Timing
- `start` sampled at edge T0.
  - `busy`=1 after T0.
  - SHIFT occupies cycles T0..T0+WIDTH-1.
  - DRAIN is at T0+WIDTH.
  - `count`, `overflow` and `done` update at edge T0+WIDTH+2.
- Latency from `start` to `done` is WIDTH+2 cycles.
- `busy` falls together with `done` (at T0+WIDTH+2).
- Back-to-back adds: `start` held high is accepted again on the cycle `done` is high (FSM is in IDLE). Throughput is one add per WIDTH+3 cycles.
- The external adder must register sum and carry with exactly 1-cycle latency on the same `clk`.

## Structure
- **Shared package `counter_pkg`:**
  - FSM state enum (IDLE, SHIFT, DRAIN, DONE).
  - Default WIDTH constant.
  - Bit-index width as `$clog2(WIDTH)`.
- **Block contents:** FSM, bit-index counter, two operand shift registers, result shift register.
- **Sub-modules:** none required. The `adder` is instanced alongside at the counter top level, not inside this block.
- **Bench:** instances this block with a behavioural 1-cycle registered full-adder model, or with `adder` itself.

## Test plan
- **Reset:** assert `rst`=0 for 3 cycles with `start`=1 → all outputs 0, no `done`, `add_*`=0.
- **Increment from zero:** `count`=0x00, `step`=0x01, `start` pulse → `done` exactly 10 cycles later (WIDTH=8), `count`=0x01, `overflow`=0, `busy` high for 10 cycles.
- **Wrap-around:** `count`=0xFF, `step`=0x01 → `count`=0x00, `overflow`=1. Next `step`=0x00 add → `count`=0x00, `overflow`=0.
- **Multi-bit carry chain:** `count`=0x5A, `step`=0x33 → `count`=0x8D, `overflow`=0. Then `step`=0x80 → `count`=0x0D, `overflow`=1. Check per-cycle `add_a/add_b/add_cin` against the expected bit sequences.
- **Ignored inputs while busy:** pulse `start` and `clr` while `busy`, and change `step` → one `done` only, result uses the originally sampled `step`. Then `clr` in IDLE → `count`=0 next cycle, no `done`.
- **Reset mid-add:** drop `rst` at SHIFT k=3 → immediate `busy`=0, `count`=0. After release, `start` with `step`=0x07 → `count`=0x07 after 10 cycles.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared definitions for the bit-serial counter datapath: FSM encoding and sizing helpers.
package counter_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_e;

    // Bit-index width; never below one bit so the counter stays a real vector.
    function automatic int idx_w(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_count_seq.sv
// Bit-serial accumulating counter sequencer: streams count and step LSB-first into an
// external 1-cycle registered full adder, collects the sum and commits count/overflow.
//
// Handshake: start/clr are sampled only while busy is low; an accepted start raises busy on
// the same edge and busy drops on the edge that raises the one-cycle done pulse.
module serial_count_seq
    import counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             clr,
    input  logic [WIDTH-1:0] step,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] count,
    output logic             overflow,
    output logic             add_a,
    output logic             add_b,
    output logic             add_cin,
    input  logic             add_s,
    input  logic             add_cout,
    output logic [1:0]       dbg_state
);

    localparam int KW = idx_w(WIDTH);
    localparam logic [KW-1:0] K_LAST = KW'(WIDTH - 1);

    seq_state_e       state_q;
    logic [KW-1:0]    k_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] res_q;
    logic             carry_q;
    logic [WIDTH-1:0] count_q;
    logic             overflow_q;
    logic             busy_q;
    logic             done_q;

    logic             in_shift_d;
    logic [WIDTH-1:0] res_d;

    assign in_shift_d = (state_q == ST_SHIFT);
    // Sum bits arrive one cycle behind their operands, so they enter from the MSB end.
    assign res_d      = {add_s, res_q[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            k_q        <= '0;
            a_sh_q     <= '0;
            b_sh_q     <= '0;
            res_q      <= '0;
            carry_q    <= 1'b0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (clr) begin
                        count_q    <= '0;
                        overflow_q <= 1'b0;
                    end else if (start) begin
                        a_sh_q  <= count_q;
                        b_sh_q  <= step;
                        k_q     <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    a_sh_q <= a_sh_q >> 1;
                    b_sh_q <= b_sh_q >> 1;
                    if (k_q != '0) begin
                        res_q <= res_d;
                    end
                    if (k_q == K_LAST) begin
                        state_q <= ST_DRAIN;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    res_q   <= res_d;
                    carry_q <= add_cout;
                    state_q <= ST_DONE;
                end
                ST_DONE: begin
                    count_q    <= res_q;
                    overflow_q <= carry_q;
                    done_q     <= 1'b1;
                    busy_q     <= 1'b0;
                    state_q    <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Carry-in is the adder's registered carry passed straight through from bit 1 onward.
    assign add_a     = in_shift_d & a_sh_q[0];
    assign add_b     = in_shift_d & b_sh_q[0];
    assign add_cin   = in_shift_d & (k_q != '0) & add_cout;

    assign busy      = busy_q;
    assign done      = done_q;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_count_seq.sv
// Bench for serial_count_seq with a behavioural 1-cycle registered full adder alongside.
module tb_serial_count_seq;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic         clr;
    logic [W-1:0] step;
    logic         busy;
    logic         done;
    logic [W-1:0] count;
    logic         overflow;
    logic         add_a;
    logic         add_b;
    logic         add_cin;
    logic         add_s;
    logic         add_cout;
    logic [1:0]   dbg_state;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model state and scoreboard.
    logic [W-1:0] m_count = '0;
    logic         m_ovf   = 1'b0;
    logic [W-1:0] exp_q[$];
    logic         exp_ovf_q[$];

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- adder model ----------------
    logic [1:0] add_r = 2'b00;
    always_ff @(posedge clk) add_r <= {1'b0, add_a} + {1'b0, add_b} + {1'b0, add_cin};
    assign add_s    = add_r[0];
    assign add_cout = add_r[1];

    serial_count_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .clr(clr), .step(step),
        .busy(busy), .done(done), .count(count), .overflow(overflow),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_s(add_s), .add_cout(add_cout), .dbg_state(dbg_state)
    );

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- drivers ----------------
    // Starts one add from IDLE and follows it to the done cycle, checking the serial stream.
    // With noise set, start/clr/step are toggled while busy and must have no effect.
    task automatic do_add(input logic [W-1:0] stp, input bit noise);
        int unsigned cnt_i, stp_i, low, sum;
        logic [W-1:0] exp_c;
        logic         exp_o;
        cnt_i = int'(m_count);
        stp_i = int'(stp);
        sum   = cnt_i + stp_i;
        exp_q.push_back(W'(sum));
        exp_ovf_q.push_back(sum[W]);

        start = 1'b1;
        clr   = 1'b0;
        step  = stp;
        tick();
        start = 1'b0;
        step  = W'($urandom);
        for (int k = 0; k < W; k++) begin
            low = (32'd1 << k) - 1;
            check("busy_shift", busy, 1);
            check("done_shift", done, 0);
            check("count_hold", count, m_count);
            check("add_a", add_a, (cnt_i >> k) & 1);
            check("add_b", add_b, (stp_i >> k) & 1);
            check("add_cin", add_cin, (((cnt_i & low) + (stp_i & low)) >> k) & 1);
            if (noise) begin
                start = 1'($urandom);
                clr   = 1'($urandom);
                step  = W'($urandom);
            end
            tick();
        end
        start = 1'b0;
        clr   = 1'b0;
        check("drain_busy", busy, 1);
        check("drain_adds", {add_a, add_b, add_cin}, 0);
        tick();
        check("donest_busy", busy, 1);
        check("donest_done", done, 0);
        check("donest_count", count, m_count);
        tick();
        exp_c = exp_q.pop_front();
        exp_o = exp_ovf_q.pop_front();
        check("done_pulse", done, 1);
        check("done_busy", busy, 0);
        check("done_count", count, exp_c);
        check("done_ovf", overflow, exp_o);
        m_count = exp_c;
        m_ovf   = exp_o;
    endtask

    task automatic idle_cycle();
        tick();
        check("idle_done", done, 0);
        check("idle_busy", busy, 0);
        check("idle_count", count, m_count);
        check("idle_ovf", overflow, m_ovf);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst   = 1'b0;
        start = 1'b1;
        clr   = 1'b0;
        step  = 8'hA5;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_outs", {busy, done, overflow, add_a, add_b, add_cin}, 0);
            check("rst_count", count, 0);
        end
        start = 1'b0;
        rst   = 1'b1;
        idle_cycle();

        // Increment from zero, wrap-around, zero step.
        do_add(8'h01, 1'b0);
        idle_cycle();
        do_add(8'hFE, 1'b0);
        do_add(8'h01, 1'b0);
        check("wrap_count", count, 8'h00);
        check("wrap_ovf", overflow, 1);
        do_add(8'h00, 1'b0);
        check("zero_ovf", overflow, 0);
        idle_cycle();

        // Multi-bit carry chain from 0x5A.
        do_add(8'h5A, 1'b0);
        do_add(8'h33, 1'b0);
        check("chain_count", count, 8'h8D);
        do_add(8'h80, 1'b0);
        check("chain2_count", count, 8'h0D);
        check("chain2_ovf", overflow, 1);
        idle_cycle();

        // Ignored inputs while busy, then clear in IDLE.
        do_add(8'h27, 1'b1);
        idle_cycle();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        m_count = '0;
        m_ovf   = 1'b0;
        check("clr_count", count, 0);
        check("clr_ovf", overflow, 0);
        check("clr_done", done, 0);
        idle_cycle();

        // Reset at bit index 3 discards the add.
        do_add(8'hC3, 1'b0);
        start = 1'b1;
        step  = 8'h11;
        tick();
        start = 1'b0;
        void'(exp_q.size());
        repeat (3) tick();
        rst = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_count", count, 0);
        check("midrst_adds", {done, overflow, add_a, add_b, add_cin}, 0);
        tick();
        rst = 1'b1;
        m_count = '0;
        m_ovf   = 1'b0;
        idle_cycle();
        do_add(8'h07, 1'b0);
        check("post_rst_count", count, 8'h07);
        idle_cycle();

        // Random adds, some back-to-back from the done cycle.
        for (int i = 0; i < 24; i++) begin
            do_add(W'($urandom), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0) idle_cycle();
        end
        idle_cycle();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "time limit");
    end

endmodule
